// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping stage: debounced buttons, start/pause/clear FSM and a
// 00.00-99.99 s BCD counter with lap freeze, feeding the packed-digit display driver.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | cleared, tick counter held at 0, waiting for startstop
//   S_RUN   | counting; lap toggles the frozen view
//   S_PAUSE | count held; startstop resumes, clear returns to S_IDLE
module stopwatch_core #(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 100,
    parameter int DB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_startstop,
    input  logic        btn_clear,
    input  logic        btn_lap,
    output logic [15:0] digit,
    output logic        running,
    output logic        lap_active,
    output logic        ovf
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TW       = $clog2(TICK_DIV);
    localparam int DW       = $clog2(DB_CYCLES + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);

    localparam int B_SS  = 0;
    localparam int B_CLR = 1;
    localparam int B_LAP = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    logic [2:0]         btn_raw;
    logic [2:0]         sync1_q, sync2_q;
    logic [2:0]         db_q, db_d;
    logic [2:0]         press_q, press_d;
    logic [2:0][DW-1:0] db_cnt_q, db_cnt_d;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [15:0]   count_q, count_d;
    logic [15:0]   lap_q, lap_d;
    logic [15:0]   digit_q, digit_d;
    logic          lap_active_q, lap_active_d;
    logic          ovf_q, ovf_d;
    logic          running_q, running_d;
    logic          tick;
    logic [16:0]   count_inc;

    assign btn_raw = {btn_lap, btn_clear, btn_startstop};

    // Carry-out in bit 16 marks the 99.99 -> 00.00 wrap.
    function automatic logic [16:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    // The press pulse is registered alongside the debounced flip, so the FSM
    // reacts DB_CYCLES + 3 edges after the raw edge.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        press_d  = '0;
        for (int b = 0; b < 3; b++) begin
            if (sync2_q[b] == db_q[b]) begin
                db_cnt_d[b] = '0;
            end else if (db_cnt_q[b] == DB_LAST) begin
                db_cnt_d[b] = '0;
                db_d[b]     = sync2_q[b];
                press_d[b]  = sync2_q[b];
            end else begin
                db_cnt_d[b] = db_cnt_q[b] + DW'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        lap_d        = lap_q;
        lap_active_d = lap_active_q;
        ovf_d        = ovf_q;
        tick_cnt_d   = '0;
        tick         = (state_q == S_RUN) && (tick_cnt_q == TICK_LAST);
        count_inc    = bcd_inc(count_q);

        if (tick) begin
            count_d = count_inc[15:0];
            if (count_inc[16]) begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            S_RUN: begin
                if (press_q[B_LAP]) begin
                    if (!lap_active_q) begin
                        lap_active_d = 1'b1;
                        lap_d        = count_q;
                    end else begin
                        lap_active_d = 1'b0;
                    end
                end
                if (press_q[B_SS]) begin
                    state_d = S_PAUSE;
                end
            end
            S_IDLE, S_PAUSE: begin
                if (press_q[B_CLR]) begin
                    state_d      = S_IDLE;
                    count_d      = '0;
                    ovf_d        = 1'b0;
                    lap_active_d = 1'b0;
                end else begin
                    if (press_q[B_LAP] && state_q == S_PAUSE) begin
                        lap_active_d = 1'b0;
                    end
                    if (press_q[B_SS]) begin
                        state_d = S_RUN;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Counter only advances while staying in RUN; any entry starts from 0.
        if (state_q == S_RUN && state_d == S_RUN && !tick) begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end

        running_d = (state_d == S_RUN);
        digit_d   = lap_active_q ? lap_q : count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            db_q         <= '0;
            press_q      <= '0;
            db_cnt_q     <= '0;
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            count_q      <= '0;
            lap_q        <= '0;
            digit_q      <= '0;
            lap_active_q <= 1'b0;
            ovf_q        <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            db_q         <= db_d;
            press_q      <= press_d;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            count_q      <= count_d;
            lap_q        <= lap_d;
            digit_q      <= digit_d;
            lap_active_q <= lap_active_d;
            ovf_q        <= ovf_d;
            running_q    <= running_d;
        end
    end

    assign digit      = digit_q;
    assign running    = running_q;
    assign lap_active = lap_active_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: directed and random button sequences, expected outputs
// from an elapsed-tick model queued with cycle stamps and checked by a monitor.
module tb_stopwatch_core;

    localparam int CLK_HZ  = 200;
    localparam int TICK_HZ = 100;
    localparam int DB      = 4;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        b_ss, b_clr, b_lap;
    logic [15:0] digit;
    logic        running, lap_active, ovf;

    stopwatch_core #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .DB_CYCLES(DB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_startstop(b_ss),
        .btn_clear    (b_clr),
        .btn_lap      (b_lap),
        .digit        (digit),
        .running      (running),
        .lap_active   (lap_active),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          stamp;
        logic [15:0] digit;
        logic        running;
        logic        lap;
        logic        ovf;
        bit          chk_digit;
        string       name;
    } obs_t;

    obs_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Model: mode 0 idle, 1 run, 2 pause; elapsed ticks since clear kept unwrapped.
    int          mode;
    int          base;
    int          run_entry;
    bit          lap_on;
    logic [15:0] lap_bcd;

    function automatic int count_at(int e);
        if (mode == 1 && e >= run_entry) return base + (e - run_entry) / DIV;
        return base;
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        int m;
        m = v % 10000;
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic expect_at(int s, string name, bit chk_digit);
        obs_t o;
        o.stamp     = s;
        o.running   = (mode == 1);
        o.lap       = lap_on;
        o.ovf       = (count_at(s) >= 10000);
        o.digit     = lap_on ? lap_bcd : to_bcd(count_at(s - 1));
        o.chk_digit = chk_digit;
        o.name      = name;
        sb_q.push_back(o);
    endtask

    task automatic apply_press(int e, bit ss, bit clr, bit lap);
        if (mode == 1) begin
            if (lap) begin
                if (!lap_on) begin
                    lap_on  = 1'b1;
                    lap_bcd = to_bcd(count_at(e - 1));
                end else begin
                    lap_on = 1'b0;
                end
            end
            if (ss) begin
                base = count_at(e);
                mode = 2;
            end
        end else if (clr) begin
            base   = 0;
            mode   = 0;
            lap_on = 1'b0;
        end else begin
            if (lap && mode == 2) lap_on = 1'b0;
            if (ss) begin
                mode      = 1;
                run_entry = e;
            end
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic observe(string name);
        expect_at(cyc + 1, name, 1'b1);
    endtask

    // Raw level first sampled at edge cyc+1; FSM reacts at edge cyc+DB+3.
    task automatic press(bit ss, bit clr, bit lap, string name);
        int e;
        e = cyc + DB + 3;
        expect_at(e - 1, {name, " pre"}, 1'b1);
        b_ss  = ss;
        b_clr = clr;
        b_lap = lap;
        apply_press(e, ss, clr, lap);
        expect_at(e, {name, " edge"}, 1'b0);
        expect_at(e + 1, {name, " post"}, 1'b1);
        step(10);
        b_ss  = 1'b0;
        b_clr = 1'b0;
        b_lap = 1'b0;
        step(10);
    endtask

    always @(negedge clk) begin
        obs_t o;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            o = sb_q[i];
            if (o.stamp < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s: check for cycle %0d never reached (now %0d)", o.name, o.stamp, cyc);
                sb_q.delete(i);
            end else if (o.stamp == cyc) begin
                n_checks++;
                if (running !== o.running || lap_active !== o.lap || ovf !== o.ovf ||
                    (o.chk_digit && digit !== o.digit)) begin
                    n_errors++;
                    $display("FAIL %s @%0d: got digit=%h running=%b lap=%b ovf=%b, want digit=%h(chk=%0d) running=%b lap=%b ovf=%b",
                             o.name, cyc, digit, running, lap_active, ovf,
                             o.digit, o.chk_digit, o.running, o.lap, o.ovf);
                end
                sb_q.delete(i);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        b_ss      = 1'b1;
        b_clr     = 1'b1;
        b_lap     = 1'b1;
        mode      = 0;
        base      = 0;
        run_entry = 0;
        lap_on    = 1'b0;
        lap_bcd   = '0;

        for (int s = 1; s <= 3; s++) expect_at(s, "reset", 1'b1);
        step(3);
        rst_n = 1'b1;
        b_ss  = 1'b0;
        b_clr = 1'b0;
        b_lap = 1'b0;
        step(15);
        observe("after reset");

        for (int i = 0; i < 10; i++) begin
            b_ss = (i % 2 == 0);
            step(2);
        end
        b_ss = 1'b0;
        step(20);
        observe("bounce");

        press(1, 0, 0, "start");
        step(123 * DIV - 20);
        observe("running");
        press(1, 0, 0, "pause");
        step(50);
        observe("hold1");
        step(100);
        observe("hold2");
        press(0, 1, 0, "clear");

        press(1, 0, 0, "wrap start");
        step(10000 * DIV - 12);
        observe("wrapped");
        step(5 * DIV);
        observe("after wrap");
        press(1, 0, 0, "wrap pause");
        press(0, 1, 0, "wrap clear");

        press(1, 0, 0, "lap start");
        step(250 * DIV - 19);
        press(0, 0, 1, "lap on");
        step(30 * DIV - 20);
        observe("lap frozen");
        press(0, 0, 1, "lap off");
        press(1, 0, 0, "lap pause");
        press(0, 1, 0, "lap clear");

        press(1, 0, 0, "prio start");
        step(42 * DIV - 20);
        press(1, 0, 0, "prio pause");
        press(1, 1, 0, "clear+ss");
        press(1, 0, 0, "prio restart");
        step(30);
        press(0, 1, 0, "clear in run");
        step(20);
        observe("run continues");
        press(1, 0, 0, "prio pause2");

        for (int it = 0; it < 40; it++) begin
            int m;
            if ($urandom_range(0, 3) < 3) begin
                m = $urandom_range(1, 7);
                press(m[0], m[1], m[2], "rand press");
            end
            step($urandom_range(0, 150));
            observe("rand idle");
        end

        step(5);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard drain: %0d checks left, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
